// File: rtl/seq_scan_pkg.sv
// seq_scan_pkg: shared state encoding for the bit-serial scan controller
package seq_scan_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;
endpackage

// File: rtl/seq_match_win.sv
// seq_match_win: sliding PAT_W-bit window that flags a pattern hit on the bit being shifted in
module seq_match_win
  import seq_scan_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             bit_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pat,
  output logic             match
);
  localparam int FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FULL = FILL_W'(PAT_W - 1);
  logic [PAT_W-1:0]  win_q, win_d, win_nx;
  logic [FILL_W-1:0] fill_q, fill_d;
  // a hit needs PAT_W-1 earlier bits already in the window plus the incoming bit
  always_comb begin
    win_nx = {win_q[PAT_W-2:0], bit_in};
    match  = bit_en && (fill_q == FULL) && (win_nx == pat);
    win_d  = clr ? '0 : bit_en ? win_nx : win_q;
    fill_d = clr ? '0 : (bit_en && fill_q != FULL) ? fill_q + FILL_W'(1) : fill_q;
  end
  // window and fill counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts a word, scans it MSB first through the matcher, returns count and first-hit index
module seq_scan_ctrl
  import seq_scan_pkg::*;
#(
  parameter  int WORD_W = 16,
  parameter  int PAT_W  = 4,
  localparam int CNT_W  = $clog2(WORD_W + 1),
  localparam int IDX_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic [PAT_W-1:0]  in_pat,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_count,
  output logic              res_found,
  output logic [IDX_W-1:0]  res_idx,
  output logic              busy
);
  state_e            state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic [IDX_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              found_q, found_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              res_valid_q, res_valid_d;
  logic              busy_q, busy_d;
  logic              accept, bit_en, match;

  seq_match_win #(.PAT_W(PAT_W)) u_win (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (accept),
    .bit_en (bit_en),
    .bit_in (shreg_q[WORD_W-1]),
    .pat    (pat_q),
    .match  (match)
  );

  // next state, scan bookkeeping and registered handshake outputs
  always_comb begin
    accept    = in_valid && in_ready_q;
    bit_en    = state_q == SHIFT;
    state_d   = state_q;
    shreg_d   = shreg_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    count_d   = count_q;
    found_d   = found_q;
    idx_d     = idx_q;
    case (state_q)
      IDLE: if (accept) begin
        state_d   = SHIFT;
        shreg_d   = in_word;
        pat_d     = in_pat;
        bit_cnt_d = '0;
        count_d   = '0;
        found_d   = 1'b0;
        idx_d     = '0;
      end
      SHIFT: begin
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q + IDX_W'(1);
        count_d   = match ? count_q + CNT_W'(1) : count_q;
        found_d   = found_q || match;
        idx_d     = (match && !found_q) ? bit_cnt_q : idx_q;
        state_d   = (bit_cnt_q == IDX_W'(WORD_W - 1)) ? DONE : SHIFT;
      end
      DONE:    state_d = res_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = state_d == IDLE;
    res_valid_d = state_d == DONE;
    busy_d      = state_d != IDLE;
  end

  // all controller state; reset returns to an idle, ready, empty controller
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      pat_q       <= '0;
      bit_cnt_q   <= '0;
      count_q     <= '0;
      found_q     <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      pat_q       <= pat_d;
      bit_cnt_q   <= bit_cnt_d;
      count_q     <= count_d;
      found_q     <= found_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;
  assign res_count = count_q;
  assign res_found = found_q;
  assign res_idx   = idx_q;
endmodule
